// File: rtl/reorder_buffer_if.sv
// Handshake bundle between decode, the MEM/WB completion path, commit and the reorder buffer.
// The master side drives requests and completions; the slave is the reorder buffer itself.
interface reorder_buffer_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_alloc_valid;
  logic [4:0]        in_alloc_rd;
  logic [2:0]        in_alloc_instr_type;
  logic [3:0]        out_alloc_idx;
  logic              out_full;
  logic              out_empty;

  logic              in_complete;
  logic [3:0]        in_complete_idx;
  logic [2:0]        in_instr_type;
  logic [DATA_W-1:0] in_result;

  logic              in_flush;

  logic              out_commit_valid;
  logic [3:0]        out_commit_idx;
  logic [4:0]        out_commit_rd;
  logic [DATA_W-1:0] out_commit_value;
  logic              out_commit_write_enable;

  modport master (
    output in_alloc_valid, in_alloc_rd, in_alloc_instr_type,
    output in_complete, in_complete_idx, in_instr_type, in_result,
    output in_flush,
    input  out_alloc_idx, out_full, out_empty,
    input  out_commit_valid, out_commit_idx, out_commit_rd, out_commit_value,
    input  out_commit_write_enable
  );

  modport slave (
    input  in_alloc_valid, in_alloc_rd, in_alloc_instr_type,
    input  in_complete, in_complete_idx, in_instr_type, in_result,
    input  in_flush,
    output out_alloc_idx, out_full, out_empty,
    output out_commit_valid, out_commit_idx, out_commit_rd, out_commit_value,
    output out_commit_write_enable
  );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocation, out-of-order completion, in-order commit.
// Flush and reset discard every in-flight entry and return both pointers to index 0.
module reorder_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave rob
);

  localparam int unsigned IdxW = 4;
  localparam int unsigned CntW = 5;
  localparam logic [2:0]  TypeStore  = 3'd2;
  localparam logic [2:0]  TypeBranch = 3'd3;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             done_q, done_d;
  logic [DEPTH-1:0][4:0]        rd_q, rd_d;
  logic [DEPTH-1:0][2:0]        type_q, type_d;
  logic [DEPTH-1:0][DATA_W-1:0] value_q, value_d;
  logic [IdxW-1:0]              head_q, head_d;
  logic [IdxW-1:0]              tail_q, tail_d;
  logic [CntW-1:0]              count_q, count_d;

  logic full;
  logic alloc_fire;
  logic complete_fire;
  logic commit_fire;

  // Fullness uses the start-of-cycle count, so a same-edge commit never admits an allocation.
  assign full          = (count_q == CntW'(DEPTH));
  assign alloc_fire    = rob.in_alloc_valid && !full;
  assign complete_fire = rob.in_complete && valid_q[rob.in_complete_idx];
  assign commit_fire   = valid_q[head_q] && done_q[head_q];

  always_comb begin
    rob.out_alloc_idx           = tail_q;
    rob.out_full                = full;
    rob.out_empty               = (count_q == '0);
    rob.out_commit_valid        = commit_fire;
    rob.out_commit_idx          = '0;
    rob.out_commit_rd           = '0;
    rob.out_commit_value        = '0;
    rob.out_commit_write_enable = 1'b0;
    if (commit_fire) begin
      rob.out_commit_idx          = head_q;
      rob.out_commit_rd           = rd_q[head_q];
      rob.out_commit_value        = value_q[head_q];
      rob.out_commit_write_enable = (type_q[head_q] != TypeStore) &&
                                    (type_q[head_q] != TypeBranch) &&
                                    (rd_q[head_q] != '0);
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rd_d    = rd_q;
    type_d  = type_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob.in_flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (complete_fire) begin
        done_d[rob.in_complete_idx]  = 1'b1;
        value_d[rob.in_complete_idx] = rob.in_result;
        type_d[rob.in_complete_idx]  = rob.in_instr_type;
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + IdxW'(1);
      end
      // The tail slot is never valid here, so it cannot collide with completion or commit.
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        rd_d[tail_q]    = rob.in_alloc_rd;
        type_d[tail_q]  = rob.in_alloc_instr_type;
        tail_d          = tail_q + IdxW'(1);
      end
      count_d = count_q + CntW'(alloc_fire) - CntW'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      rd_q    <= '0;
      type_q  <= '0;
      value_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      type_q  <= type_d;
      value_q <= value_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: an in-order queue model of live instructions checked every cycle,
// plus directed scenarios with literal expectations and a long randomized run.
module tb_reorder_buffer;

  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [3:0]        idx;
    logic [4:0]        rd;
    logic [2:0]        ty;
    logic              done;
    logic [DATA_W-1:0] val;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // Live instructions, oldest first; an entry is valid exactly when it is in this queue.
  ent_t       mq[$];
  logic [3:0] m_next = '0;

  reorder_buffer_if #(.DATA_W(DATA_W)) rob_if ();

  reorder_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rob  (rob_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    rob_if.in_alloc_valid      = 1'b0;
    rob_if.in_alloc_rd         = '0;
    rob_if.in_alloc_instr_type = '0;
    rob_if.in_complete         = 1'b0;
    rob_if.in_complete_idx     = '0;
    rob_if.in_instr_type       = '0;
    rob_if.in_result           = '0;
    rob_if.in_flush            = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_next = '0;
  endtask

  task automatic model_update();
    int   pre;
    bit   commit;
    ent_t e;
    if (!reset) return;
    pre    = mq.size();
    commit = (pre > 0) && mq[0].done;
    if (rob_if.in_flush) begin
      model_reset();
      return;
    end
    if (rob_if.in_complete) begin
      foreach (mq[i]) begin
        if (mq[i].idx == rob_if.in_complete_idx) begin
          mq[i].done = 1'b1;
          mq[i].val  = rob_if.in_result;
          mq[i].ty   = rob_if.in_instr_type;
        end
      end
    end
    if (commit) void'(mq.pop_front());
    if (rob_if.in_alloc_valid && pre < 16) begin
      e.idx  = m_next;
      e.rd   = rob_if.in_alloc_rd;
      e.ty   = rob_if.in_alloc_instr_type;
      e.done = 1'b0;
      e.val  = '0;
      mq.push_back(e);
      m_next = m_next + 4'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [2:0] ty);
    rob_if.in_alloc_valid      = 1'b1;
    rob_if.in_alloc_rd         = rd;
    rob_if.in_alloc_instr_type = ty;
  endtask

  task automatic complete(input logic [3:0] idx, input logic [2:0] ty, input logic [31:0] val);
    rob_if.in_complete     = 1'b1;
    rob_if.in_complete_idx = idx;
    rob_if.in_instr_type   = ty;
    rob_if.in_result       = val;
  endtask

  // Every-cycle comparison of all outputs against the queue model.
  bit   exp_cv;
  bit   exp_we;
  ent_t hd;
  always @(negedge clk) begin
    exp_cv = (mq.size() > 0) && mq[0].done;
    check("empty", 64'(rob_if.out_empty), 64'(mq.size() == 0));
    check("full", 64'(rob_if.out_full), 64'(mq.size() == 16));
    check("alloc_idx", 64'(rob_if.out_alloc_idx), 64'(m_next));
    check("commit_valid", 64'(rob_if.out_commit_valid), 64'(exp_cv));
    if (exp_cv) begin
      hd     = mq[0];
      exp_we = (hd.ty != 3'd2) && (hd.ty != 3'd3) && (hd.rd != 5'd0);
      check("commit_idx", 64'(rob_if.out_commit_idx), 64'(hd.idx));
      check("commit_rd", 64'(rob_if.out_commit_rd), 64'(hd.rd));
      check("commit_value", 64'(rob_if.out_commit_value), 64'(hd.val));
      check("commit_we", 64'(rob_if.out_commit_write_enable), 64'(exp_we));
    end else begin
      check("commit_idx_zero", 64'(rob_if.out_commit_idx), 64'd0);
      check("commit_rd_zero", 64'(rob_if.out_commit_rd), 64'd0);
      check("commit_value_zero", 64'(rob_if.out_commit_value), 64'd0);
      check("commit_we_zero", 64'(rob_if.out_commit_write_enable), 64'd0);
    end
  end

  int unsigned pa;
  int unsigned pick;

  initial begin
    idle();
    #1;
    do_reset();
    check("rst_empty", 64'(rob_if.out_empty), 64'd1);
    check("rst_full", 64'(rob_if.out_full), 64'd0);
    check("rst_alloc_idx", 64'(rob_if.out_alloc_idx), 64'd0);

    // Single ALU instruction: allocate, complete, commit next cycle.
    alloc(5'd5, 3'd0); step();
    check("d1_alloc_idx", 64'(rob_if.out_alloc_idx), 64'd1);
    check("d1_not_empty", 64'(rob_if.out_empty), 64'd0);
    complete(4'd0, 3'd0, 32'h0000_00AA); step();
    check("d1_cv", 64'(rob_if.out_commit_valid), 64'd1);
    check("d1_rd", 64'(rob_if.out_commit_rd), 64'd5);
    check("d1_value", 64'(rob_if.out_commit_value), 64'hAA);
    check("d1_we", 64'(rob_if.out_commit_write_enable), 64'd1);
    step();
    check("d1_empty_after", 64'(rob_if.out_empty), 64'd1);

    // Out-of-order completion, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(5'(i + 1), 3'd0); step();
    end
    complete(4'd2, 3'd0, 32'h22); step();
    check("d2_no_commit_a", 64'(rob_if.out_commit_valid), 64'd0);
    complete(4'd1, 3'd0, 32'h11); step();
    check("d2_no_commit_b", 64'(rob_if.out_commit_valid), 64'd0);
    complete(4'd0, 3'd0, 32'h10); step();
    for (int i = 0; i < 3; i++) begin
      check("d2_commit_valid", 64'(rob_if.out_commit_valid), 64'd1);
      check("d2_commit_idx", 64'(rob_if.out_commit_idx), 64'(i));
      step();
    end
    check("d2_empty", 64'(rob_if.out_empty), 64'd1);

    // Fill, overflow request, commit-while-full rejection.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i + 1), 3'd4); step();
    end
    check("d3_full", 64'(rob_if.out_full), 64'd1);
    check("d3_tail_wrap", 64'(rob_if.out_alloc_idx), 64'd0);
    alloc(5'd9, 3'd0); step();
    check("d3_17th_ignored", 64'(rob_if.out_full), 64'd1);
    check("d3_17th_tail", 64'(rob_if.out_alloc_idx), 64'd0);
    complete(4'd0, 3'd1, 32'hDEAD_BEEF); step();
    check("d3_head_ready", 64'(rob_if.out_commit_valid), 64'd1);
    alloc(5'd9, 3'd0); step();
    check("d3_rejected_full", 64'(rob_if.out_full), 64'd0);
    check("d3_rejected_idx", 64'(rob_if.out_alloc_idx), 64'd0);
    alloc(5'd9, 3'd0); step();
    check("d3_granted_full", 64'(rob_if.out_full), 64'd1);
    check("d3_granted_idx", 64'(rob_if.out_alloc_idx), 64'd1);

    // STORE and rd=0 never write; reserved type does.
    do_reset();
    alloc(5'd7, 3'd2); step();
    alloc(5'd0, 3'd0); step();
    alloc(5'd3, 3'd6); step();
    complete(4'd0, 3'd2, 32'h77); step();
    check("d4_store_cv", 64'(rob_if.out_commit_valid), 64'd1);
    check("d4_store_we", 64'(rob_if.out_commit_write_enable), 64'd0);
    complete(4'd1, 3'd0, 32'h01); step();
    check("d4_rd0_cv", 64'(rob_if.out_commit_valid), 64'd1);
    check("d4_rd0_we", 64'(rob_if.out_commit_write_enable), 64'd0);
    complete(4'd2, 3'd5, 32'h55); step();
    check("d4_resv_we", 64'(rob_if.out_commit_write_enable), 64'd1);
    step();

    // Flush with a concurrent completion while the head is committable.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(5'(i + 4), 3'd0); step();
    end
    complete(4'd0, 3'd0, 32'h44); step();
    check("d5_preflush_cv", 64'(rob_if.out_commit_valid), 64'd1);
    rob_if.in_flush = 1'b1;
    complete(4'd1, 3'd0, 32'h45); step();
    check("d5_empty", 64'(rob_if.out_empty), 64'd1);
    check("d5_no_commit", 64'(rob_if.out_commit_valid), 64'd0);
    check("d5_tail", 64'(rob_if.out_alloc_idx), 64'd0);
    step(); step();
    check("d5_still_no_commit", 64'(rob_if.out_commit_valid), 64'd0);
    alloc(5'd1, 3'd0); step();
    check("d5_realloc", 64'(rob_if.out_alloc_idx), 64'd1);

    // Asynchronous reset between edges with live entries.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(5'(i + 8), 3'd0); step();
    end
    complete(4'd0, 3'd0, 32'h99); step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("d6_empty", 64'(rob_if.out_empty), 64'd1);
    check("d6_full", 64'(rob_if.out_full), 64'd0);
    check("d6_idx", 64'(rob_if.out_alloc_idx), 64'd0);
    check("d6_cv", 64'(rob_if.out_commit_valid), 64'd0);
    check("d6_value", 64'(rob_if.out_commit_value), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    check("d6_first_idx", 64'(rob_if.out_alloc_idx), 64'd0);
    alloc(5'd2, 3'd0); step();
    check("d6_after_idx", 64'(rob_if.out_alloc_idx), 64'd1);

    // Randomized traffic with alternating allocation pressure.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      pa = (((cyc / 250) % 3) == 0) ? 90 : ((((cyc / 250) % 3) == 1) ? 50 : 15);
      rob_if.in_alloc_valid      = ($urandom_range(0, 99) < pa);
      rob_if.in_alloc_rd         = 5'($urandom);
      rob_if.in_alloc_instr_type = 3'($urandom);
      if ($urandom_range(0, 99) < 60) begin
        rob_if.in_complete = 1'b1;
        if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
          pick = $urandom_range(0, mq.size() - 1);
          rob_if.in_complete_idx = mq[pick].idx;
        end else begin
          rob_if.in_complete_idx = 4'($urandom);
        end
        rob_if.in_instr_type = 3'($urandom);
        rob_if.in_result     = $urandom;
      end
      rob_if.in_flush = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
